// File: rtl/ln_stat_acc_pkg.sv
// ln_stat_acc_pkg
//   Shared constants and arithmetic helpers for the per-entry statistics
//   accumulator (ln_stat_acc) and its entry buffer (ln_stat_buf).
//   - DEF_* : default widths. The accumulator width is derived from the
//             input width plus headroom for 2^DEF_PASS_LOG2 channel passes.
//   - wide_t: signed working type, wide enough for every helper operand.
//   - sat_to / round_half_up: signed clamp and round-half-up helpers.
package ln_stat_acc_pkg;

  localparam int unsigned DEF_IN_W       = 24;
  localparam int unsigned DEF_PASS_LOG2  = 8;
  localparam int unsigned DEF_ACC_W      = 2 * DEF_IN_W + DEF_PASS_LOG2;
  localparam int unsigned DEF_RECIP_W    = 17;
  localparam int unsigned DEF_OUT_W      = 40;
  localparam int unsigned DEF_DEPTH      = 32;
  localparam int unsigned DEF_LOG2_DEPTH = 5;
  localparam int unsigned MAX_W          = 128;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef enum logic {
    OP_MEAN   = 1'b0,
    OP_MEANSQ = 1'b1
  } op_mode_e;

  // Clamp v to the signed range of a w-bit value.
  function automatic wide_t sat_to(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Drop frac fraction bits, rounding half-up (adds the first dropped bit).
  function automatic wide_t round_half_up(input wide_t p, input int unsigned frac);
    return (p >>> frac) + wide_t'({1'b0, p[frac-1]});
  endfunction

endpackage

// File: rtl/ln_stat_buf.sv
// ln_stat_buf
//   Simple dual-port entry buffer: one write port, one registered read port,
//   no reset (contents are always rewritten by a first pass before use).
//   Ports: clk; we/waddr/wdata write port; raddr read address;
//          rdata read data, valid the cycle after raddr is presented.
module ln_stat_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned W     = 56
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ln_stat_acc.sv
// ln_stat_acc
//   Accumulates per-entry partial sums (x or x*x) over several channel
//   passes of a DEPTH-entry stripe, then scales each sum by 1/C on the final
//   pass, rounds half-up and clamps to OUT_W. One entry per cycle, results
//   4 cycles after acceptance, in entry order.
//   Ports: clk, rst (sync, active-high); dat_vld_i/dat_i entry input;
//          sq_mode_i mean/mean-square select; recip_i 1/C (Q0.RECIP_W);
//          stripe_end_i last entry of a pass; last_pass_i final pass level;
//          dat_out_vld/dat_out result; acc_sat_o, ptr_err_o sticky flags.
module ln_stat_acc
  import ln_stat_acc_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned RECIP_W    = DEF_RECIP_W,
  parameter int unsigned OUT_W      = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dat_vld_i,
  input  logic signed [IN_W-1:0]  dat_i,
  input  logic                    sq_mode_i,
  input  logic [RECIP_W-1:0]      recip_i,
  input  logic                    stripe_end_i,
  input  logic                    last_pass_i,
  output logic                    dat_out_vld,
  output logic signed [OUT_W-1:0] dat_out,
  output logic                    acc_sat_o,
  output logic                    ptr_err_o
);

  localparam int unsigned PROD_W = ACC_W + RECIP_W + 1;

  logic [LOG2_DEPTH-1:0]    ptr_q;
  logic                     first_pass_q;
  op_mode_e                 sq_mode_q;
  logic                     sq_latch;
  op_mode_e                 sq_eff;
  logic signed [ACC_W-1:0]  op;

  // Stage 1 (accept -> read data available)
  logic                     v1, first_d1, last_d1;
  logic [LOG2_DEPTH-1:0]    ptr_d1;
  logic signed [ACC_W-1:0]  op_d1;
  logic                     fwd_q;
  logic signed [ACC_W-1:0]  fwd_dat_q;

  logic signed [ACC_W-1:0]  rd_dat, base, sum;
  wide_t                    add_raw, add_sat;
  logic                     sat_hit;

  logic                     acc_we, wb_we, buf_we;
  logic [LOG2_DEPTH-1:0]    buf_waddr;
  logic signed [ACC_W-1:0]  buf_wdata;

  logic                     v2, v3, v4;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rnd_q;
  logic signed [OUT_W-1:0]  res_q;

  always_comb begin
    sq_latch = dat_vld_i && first_pass_q && (ptr_q == '0);
    sq_eff   = sq_latch ? op_mode_e'(sq_mode_i) : sq_mode_q;
    op       = (sq_eff == OP_MEANSQ) ? ACC_W'(wide_t'(dat_i) * wide_t'(dat_i))
                                     : ACC_W'(wide_t'(dat_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      first_pass_q <= 1'b1;
      sq_mode_q    <= OP_MEAN;
      ptr_err_o    <= 1'b0;
    end else if (dat_vld_i) begin
      if (sq_latch) sq_mode_q <= sq_eff;
      if (stripe_end_i) begin
        ptr_q        <= '0;
        first_pass_q <= last_pass_i;
      end else if (ptr_q == LOG2_DEPTH'(DEPTH - 1)) begin
        ptr_q     <= '0;
        ptr_err_o <= 1'b1;
      end else begin
        ptr_q <= ptr_q + LOG2_DEPTH'(1);
      end
    end
  end

  // A read issued in the same cycle as a write to the same entry returns
  // stale data; remember the write and substitute it one cycle later.
  always_comb begin
    base    = fwd_q ? fwd_dat_q : rd_dat;
    add_raw = wide_t'(base) + wide_t'(op_d1);
    add_sat = sat_to(add_raw, ACC_W);
    sat_hit = v1 && !first_d1 && (add_sat != add_raw);
    sum     = first_d1 ? op_d1 : ACC_W'(add_sat);
  end

  // First-pass writes happen at accept; later passes write back one cycle
  // after. The final pass skips write-back: its sums are consumed by the
  // scaler, and the next first-pass write may occupy the port that cycle.
  always_comb begin
    acc_we    = dat_vld_i && first_pass_q;
    wb_we     = v1 && !first_d1 && !last_d1;
    buf_we    = acc_we || wb_we;
    buf_waddr = acc_we ? ptr_q : ptr_d1;
    buf_wdata = acc_we ? op : sum;
  end

  ln_stat_buf #(
    .DEPTH (DEPTH),
    .AW    (LOG2_DEPTH),
    .W     (ACC_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (ptr_q),
    .rdata (rd_dat)
  );

  always_comb begin
    prod = PROD_W'(sum_q) * PROD_W'($signed({1'b0, recip_i}));
  end

  always_ff @(posedge clk) begin
    op_d1     <= op;
    ptr_d1    <= ptr_q;
    first_d1  <= first_pass_q;
    last_d1   <= last_pass_i;
    fwd_dat_q <= buf_wdata;
    sum_q     <= sum;
    rnd_q     <= (ACC_W + 1)'(round_half_up(wide_t'(prod), RECIP_W));
    res_q     <= OUT_W'(sat_to(wide_t'(rnd_q), OUT_W));
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      v4          <= 1'b0;
      fwd_q       <= 1'b0;
      dat_out_vld <= 1'b0;
      dat_out     <= '0;
      acc_sat_o   <= 1'b0;
    end else begin
      v1          <= dat_vld_i;
      v2          <= v1 && last_d1;
      v3          <= v2;
      v4          <= v3;
      fwd_q       <= buf_we && (buf_waddr == ptr_q);
      dat_out_vld <= v4;
      if (v4) dat_out <= res_q;
      if (sat_hit) acc_sat_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ln_stat_acc.sv
// tb_ln_stat_acc
//   Scoreboard bench for ln_stat_acc: the driver updates a behavioural model
//   per accepted entry and queues the expected result with its due cycle; a
//   negedge monitor pops and compares whenever dat_out_vld is seen.
module tb_ln_stat_acc;

  localparam int unsigned IN_W       = 16;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned LOG2_DEPTH = 2;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned RECIP_W    = 17;
  localparam int unsigned OUT_W      = 24;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    dat_vld_i;
  logic signed [IN_W-1:0]  dat_i;
  logic                    sq_mode_i;
  logic [RECIP_W-1:0]      recip_i;
  logic                    stripe_end_i;
  logic                    last_pass_i;
  logic                    dat_out_vld;
  logic signed [OUT_W-1:0] dat_out;
  logic                    acc_sat_o;
  logic                    ptr_err_o;

  ln_stat_acc #(
    .IN_W       (IN_W),
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH),
    .ACC_W      (ACC_W),
    .RECIP_W    (RECIP_W),
    .OUT_W      (OUT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dat_vld_i    (dat_vld_i),
    .dat_i        (dat_i),
    .sq_mode_i    (sq_mode_i),
    .recip_i      (recip_i),
    .stripe_end_i (stripe_end_i),
    .last_pass_i  (last_pass_i),
    .dat_out_vld  (dat_out_vld),
    .dat_out      (dat_out),
    .acc_sat_o    (acc_sat_o),
    .ptr_err_o    (ptr_err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      val;
    int unsigned due;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad = 0;
  int     vld_seen = 0;

  // Reference model: running sums per entry plus pass bookkeeping.
  longint macc[DEPTH];
  int     mptr;
  bit     mfirst, msq, m_sat, m_err;

  function automatic longint satw(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (dat_out_vld) begin
      vld_seen++;
      if (sb.size() == 0) chk("unexpected_vld", dat_out_vld, 0);
      else begin
        mon_e = sb.pop_front();
        chk("dat_out", dat_out, mon_e.val);
        chk("latency", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      mon_e = sb.pop_front();
      chk("missing_vld", dat_out_vld, 1);
    end
  end

  task automatic drive(input bit v, input longint x, input bit se, input bit lp, input bit sq);
    longint op, raw, s, o;
    dat_vld_i    = v;
    dat_i        = IN_W'(x);
    stripe_end_i = se;
    last_pass_i  = lp;
    sq_mode_i    = sq;
    if (v) begin
      if (mfirst && mptr == 0) msq = sq;
      op = msq ? x * x : x;
      if (mfirst) s = op;
      else begin
        raw = macc[mptr] + op;
        s   = satw(raw, ACC_W);
        if (s != raw) m_sat = 1'b1;
      end
      if (lp) begin
        o = satw((s * longint'(recip_i) + (64'sd1 <<< (RECIP_W - 1))) >>> RECIP_W, OUT_W);
        sb.push_back('{o, cyc + 5});
      end else begin
        macc[mptr] = s;
      end
      if (se) begin
        mptr   = 0;
        mfirst = lp;
      end else if (mptr == DEPTH - 1) begin
        mptr  = 0;
        m_err = 1'b1;
      end else begin
        mptr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    mptr = 0; mfirst = 1'b1; msq = 1'b0; m_sat = 1'b0; m_err = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic run_acc(input int len, input int passes, input bit gaps);
    logic signed [IN_W-1:0] r;
    for (int p = 0; p < passes; p++) begin
      for (int e = 0; e < len; e++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        r = IN_W'($urandom);
        drive(1'b1, r, e == len - 1, p == passes - 1, 1'($urandom_range(0, 1)));
      end
    end
    idle(6);
  endtask

  int v0;

  initial begin
    rst = 1'b1; dat_vld_i = 1'b0; dat_i = '0; sq_mode_i = 1'b0;
    recip_i = '0; stripe_end_i = 1'b0; last_pass_i = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_vld", dat_out_vld, 0);
    chk("rst_dat_out", dat_out, 0);
    chk("rst_acc_sat", acc_sat_o, 0);
    chk("rst_ptr_err", ptr_err_o, 0);
    chk("rst_ptr", dut.ptr_q, 0);

    // Two passes of 4 entries, mean, recip = 1/2.
    recip_i = RECIP_W'(1 << 16);
    for (int e = 0; e < 4; e++) drive(1'b1, e + 1, e == 3, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) drive(1'b1, e + 5, e == 3, 1'b1, 1'b0);
    idle(6);

    // Single entry, single pass, mean-square.
    recip_i = RECIP_W'(12345);
    drive(1'b1, -3, 1'b1, 1'b1, 1'b1);
    idle(6);

    // One-entry stripes back to back: exercises write forwarding.
    recip_i = RECIP_W'(40000);
    for (int p = 0; p < 3; p++) drive(1'b1, 7, 1'b1, p == 2, 1'b0);
    idle(6);

    // Accumulator saturation: two squares of -2^15 exceed ACC_W.
    do_reset();
    recip_i = RECIP_W'(1 << 16);
    drive(1'b1, -32768, 1'b1, 1'b0, 1'b1);
    drive(1'b1, -32768, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("acc_sat_set", acc_sat_o, 1);

    // DEPTH+1 entries without stripe_end.
    do_reset();
    for (int e = 0; e < DEPTH + 1; e++) drive(1'b1, e, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("ptr_err_set", ptr_err_o, 1);
    chk("ptr_after_wrap", dut.ptr_q, 1);

    // Reset during the final pass: nothing from it may emerge.
    do_reset();
    recip_i = RECIP_W'(70000);
    for (int e = 0; e < 4; e++) drive(1'b1, 100 * (e + 1), e == 3, 1'b0, 1'b0);
    drive(1'b1, 11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 22, 1'b0, 1'b1, 1'b0);
    v0 = vld_seen;
    do_reset();
    idle(8);
    chk("no_vld_after_rst", vld_seen - v0, 0);
    for (int e = 0; e < 3; e++) drive(1'b1, -50 * (e + 1), e == 2, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) drive(1'b1, 9 + e, e == 2, 1'b1, 1'b0);
    idle(6);

    // Randomized accumulations.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      recip_i = RECIP_W'($urandom);
      run_acc($urandom_range(1, DEPTH), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    chk("rand_acc_sat", acc_sat_o, longint'(m_sat));
    chk("rand_ptr_err", ptr_err_o, longint'(m_err));

    idle(8);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
